// File: rtl/ws2811_pkg.sv
// Shared types and colour helpers for the WS2811 frame sequencer and sibling colour blocks.
package ws2811_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE
   } seq_state_e;

   localparam int MAX_COLOR_WIDTH = 16;

   function automatic int pixel_width(input int color_width);
      return 3 * color_width;
   endfunction

   // (c * (brightness + 1)) >> 8, so 255 is unity gain and 0 keeps only the top bits.
   function automatic logic [MAX_COLOR_WIDTH-1:0] scale_color(
      input logic [MAX_COLOR_WIDTH-1:0] c,
      input logic [7:0]                 brightness
   );
      logic [MAX_COLOR_WIDTH+8:0] prod;
      prod = {9'd0, c} * {{MAX_COLOR_WIDTH{1'b0}}, {1'b0, brightness} + 9'd1};
      return MAX_COLOR_WIDTH'(prod >> 8);
   endfunction

endpackage

// File: rtl/ws2811_frame_sequencer_if.sv
// Pattern-ROM and transmitter handshake bundle of the frame sequencer; master is the sequencer side.
interface ws2811_frame_sequencer_if #(
   parameter int AW = 7,
   parameter int D  = 24
);
   logic          enableIN;
   logic          directionIN;
   logic [AW-1:0] stepIN;
   logic [7:0]    brightnessIN;
   logic [AW-1:0] romAddressOUT;
   logic [D-1:0]  romDataIN;
   logic          txStartOUT;
   logic [D-1:0]  txDataOUT;
   logic          txBusyIN;
   logic          busyOUT;
   logic          frameDoneOUT;
   logic          overrunOUT;

   modport master (
      input  enableIN, directionIN, stepIN, brightnessIN, romDataIN, txBusyIN,
      output romAddressOUT, txStartOUT, txDataOUT, busyOUT, frameDoneOUT, overrunOUT
   );

   modport slave (
      output enableIN, directionIN, stepIN, brightnessIN, romDataIN, txBusyIN,
      input  romAddressOUT, txStartOUT, txDataOUT, busyOUT, frameDoneOUT, overrunOUT
   );
endinterface

// File: rtl/ws2811_frame_ticker.sv
// Free-running period counter: tick_o is high for one cycle at count PERIOD-1, every PERIOD cycles.
module ws2811_frame_ticker #(
   parameter int PERIOD = 2_500_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);
   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/ws2811_frame_sequencer.sv
// Streams one scrolled, brightness-scaled pattern frame per update period from the ROM to the WS2811 transmitter.
module ws2811_frame_sequencer
   import ws2811_pkg::*;
#(
   parameter int UNITS_NUMBER          = 100,
   parameter int PATTERN_PIXELS_NUMBER = 128,
   parameter int CLOCK_SPEED           = 50_000_000,
   parameter int UPDATES_PER_SECOND    = 20,
   parameter int ROM_LATENCY           = 1,
   parameter int COLOR_WIDTH           = 8
) (
   input logic                       clkIN,
   input logic                       nResetIN,
   ws2811_frame_sequencer_if.master  sif
);
   localparam int AW     = $clog2(PATTERN_PIXELS_NUMBER);
   localparam int UW     = $clog2(UNITS_NUMBER + 1);
   localparam int D      = pixel_width(COLOR_WIDTH);
   localparam int PERIOD = CLOCK_SPEED / UPDATES_PER_SECOND;
   localparam int FW     = $clog2(ROM_LATENCY + 1);
   localparam logic [AW:0]    DEPTH     = (AW+1)'(PATTERN_PIXELS_NUMBER);
   localparam logic [UW-1:0]  LAST_UNIT = UW'(UNITS_NUMBER - 1);
   localparam logic [FW-1:0]  LAT_LAST  = FW'(ROM_LATENCY);

   logic tick;

   ws2811_frame_ticker #(.PERIOD(PERIOD)) u_ticker (
      .clk    (clkIN),
      .rst_n  (nResetIN),
      .tick_o (tick)
   );

   seq_state_e    state_q, state_d;
   logic [AW-1:0] offset_q, offset_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [UW-1:0] unit_q, unit_d;
   logic [FW-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [7:0]    bright_q, bright_d;
   logic [D-1:0]  tx_data_q, tx_data_d;
   logic          frame_done_q, frame_done_d;
   logic          overrun_q, overrun_d;

   logic [AW:0]   fwd_w, back_w, inc_w;
   logic [AW-1:0] new_offset_w;
   logic [D-1:0]  scaled_w;

   // Modular steps are kept one bit wider so non-power-of-two depths wrap correctly.
   always_comb begin
      fwd_w = {1'b0, offset_q} + {1'b0, sif.stepIN};
      if (fwd_w >= DEPTH) fwd_w = fwd_w - DEPTH;
      back_w = {1'b0, offset_q} - {1'b0, sif.stepIN};
      if (back_w[AW]) back_w = back_w + DEPTH;
      inc_w = {1'b0, addr_q} + (AW+1)'(1);
      if (inc_w >= DEPTH) inc_w = inc_w - DEPTH;
      new_offset_w = sif.directionIN ? back_w[AW-1:0] : fwd_w[AW-1:0];
   end

   always_comb begin
      scaled_w = '0;
      for (int i = 0; i < 3; i++) begin
         scaled_w[i*COLOR_WIDTH +: COLOR_WIDTH] = COLOR_WIDTH'(scale_color(
            MAX_COLOR_WIDTH'(sif.romDataIN[i*COLOR_WIDTH +: COLOR_WIDTH]), bright_q));
      end
   end

   always_comb begin
      state_d      = state_q;
      offset_d     = offset_q;
      addr_d       = addr_q;
      unit_d       = unit_q;
      fetch_cnt_d  = fetch_cnt_q;
      bright_d     = bright_q;
      tx_data_d    = tx_data_q;
      frame_done_d = 1'b0;
      overrun_d    = tick && (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (tick && sif.enableIN) begin
               offset_d    = new_offset_w;
               addr_d      = new_offset_w;
               unit_d      = '0;
               bright_d    = sif.brightnessIN;
               fetch_cnt_d = '0;
               state_d     = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // The address flop itself takes a cycle, so FETCH spans ROM_LATENCY+1 cycles.
            if (fetch_cnt_q == LAT_LAST) begin
               tx_data_d   = scaled_w;
               fetch_cnt_d = '0;
               state_d     = ST_ISSUE;
            end else begin
               fetch_cnt_d = fetch_cnt_q + FW'(1);
            end
         end
         ST_ISSUE: begin
            if (!sif.txBusyIN) state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (sif.txBusyIN) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!sif.txBusyIN) begin
               unit_d = unit_q + UW'(1);
               if (unit_q == LAST_UNIT) begin
                  frame_done_d = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  addr_d  = inc_w[AW-1:0];
                  state_d = ST_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clkIN or negedge nResetIN) begin
      if (!nResetIN) begin
         state_q      <= ST_IDLE;
         offset_q     <= '0;
         addr_q       <= '0;
         unit_q       <= '0;
         fetch_cnt_q  <= '0;
         bright_q     <= '0;
         tx_data_q    <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         offset_q     <= offset_d;
         addr_q       <= addr_d;
         unit_q       <= unit_d;
         fetch_cnt_q  <= fetch_cnt_d;
         bright_q     <= bright_d;
         tx_data_q    <= tx_data_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   // Start is qualified by the live busy input so it fires in the ISSUE cycle itself.
   assign sif.txStartOUT    = (state_q == ST_ISSUE) && !sif.txBusyIN;
   assign sif.romAddressOUT = addr_q;
   assign sif.txDataOUT     = tx_data_q;
   assign sif.busyOUT       = (state_q != ST_IDLE);
   assign sif.frameDoneOUT  = frame_done_q;
   assign sif.overrunOUT    = overrun_q;
endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Directed bench: 4 units, 8-entry ROM holding its own address, 200-cycle period, transmitter model.
module tb_ws2811_frame_sequencer;
   localparam int AW = 3;
   localparam int D  = 24;

   logic clk_in  = 1'b0;
   logic n_reset = 1'b0;
   always #5 clk_in = ~clk_in;

   ws2811_frame_sequencer_if #(.AW(AW), .D(D)) sif ();

   ws2811_frame_sequencer #(
      .UNITS_NUMBER          (4),
      .PATTERN_PIXELS_NUMBER (8),
      .CLOCK_SPEED           (4000),
      .UPDATES_PER_SECOND    (20),
      .ROM_LATENCY           (1),
      .COLOR_WIDTH           (8)
   ) dut (
      .clkIN    (clk_in),
      .nResetIN (n_reset),
      .sif      (sif)
   );

   int vectors = 0;
   int miscompares = 0;

   int       cyc = 0;
   int       busy_len = 10;
   int       tx_cnt = 0;
   bit       rom_mode = 1'b0;
   logic [D-1:0] rom_q = '0;
   logic [D-1:0] sent_q[$];
   int       done_cnt = 0, ovr_cnt = 0, starts = 0, last_start = 0, last_gap = 0;
   bit       busy_prev = 1'b0, done_busy_seen = 1'b0;

   always @(posedge clk_in) cyc <= cyc + 1;
   always @(posedge clk_in) rom_q <= rom_mode ? 24'hC8C8C8 : {21'd0, sif.romAddressOUT};
   assign sif.romDataIN = rom_q;

   always @(posedge clk_in) begin
      if (tx_cnt != 0)          tx_cnt <= tx_cnt - 1;
      else if (sif.txStartOUT)  tx_cnt <= busy_len;
   end
   assign sif.txBusyIN = (tx_cnt != 0);

   always @(negedge clk_in) begin
      if (sif.txStartOUT) sent_q.push_back(sif.txDataOUT);
      if (sif.frameDoneOUT) begin
         done_cnt++;
         if (sif.busyOUT) done_busy_seen = 1'b1;
      end
      if (sif.overrunOUT) ovr_cnt++;
      if (sif.busyOUT && !busy_prev) begin
         starts++;
         last_gap   = cyc - last_start;
         last_start = cyc;
      end
      busy_prev = sif.busyOUT;
   end

   function automatic logic [4*D-1:0] got4();
      got4 = '1;
      if (sent_q.size() == 4) got4 = {sent_q[0], sent_q[1], sent_q[2], sent_q[3]};
   endfunction

   task automatic release_and_wait(output int n);
      @(posedge clk_in); #1;
      n_reset = 1'b1;
      sent_q.delete();
      ovr_cnt = 0;
      n = 0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk_in); #1;
         n++;
         if (sif.busyOUT) break;
      end
   endtask

   task automatic restart(output int n);
      n_reset = 1'b0;
      repeat (2) @(posedge clk_in);
      release_and_wait(n);
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int target;
      target = done_cnt + 1;
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk_in); #1;
         if (done_cnt >= target) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_start(input int budget, output bit ok);
      int target;
      target = starts + 1;
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk_in); #1;
         if (starts >= target) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      int n, m;
      repeat (3) @(posedge clk_in); #1;
      vectors++;
      if ({sif.busyOUT, sif.txStartOUT, sif.frameDoneOUT, sif.overrunOUT} !== 4'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b, expected 0000",
                  {sif.busyOUT, sif.txStartOUT, sif.frameDoneOUT, sif.overrunOUT});
      end
      vectors++;
      if (sif.romAddressOUT !== 3'd0) begin
         miscompares++; $display("FAIL reset_addr: got %0d, expected 0", sif.romAddressOUT);
      end
      vectors++;
      if (sif.txDataOUT !== 24'd0) begin
         miscompares++; $display("FAIL reset_data: got %h, expected 000000", sif.txDataOUT);
      end
      sif.enableIN = 1'b1; sif.stepIN = 3'd1; sif.directionIN = 1'b0; sif.brightnessIN = 8'd255;
      release_and_wait(n);
      vectors++;
      if (n !== 200) begin
         miscompares++; $display("FAIL first_start_cycle: got %0d, expected 200", n);
      end
      vectors++;
      if (sif.romAddressOUT !== 3'd1) begin
         miscompares++; $display("FAIL first_addr: got %0d, expected 1", sif.romAddressOUT);
      end
      m = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk_in); #1;
         m++;
         if (sif.txStartOUT) break;
      end
      vectors++;
      if (m !== 2) begin
         miscompares++; $display("FAIL fetch_to_start: got %0d, expected 2", m);
      end
   endtask

   task automatic test_scroll_step1();
      bit ok;
      wait_done(600, ok);
      vectors++;
      if (!ok || got4() !== {24'd1, 24'd2, 24'd3, 24'd4}) begin
         miscompares++; $display("FAIL step1_frame1: got %h, expected 000001000002000003000004", got4());
      end
      vectors++;
      if (done_cnt !== 1) begin
         miscompares++; $display("FAIL step1_done_count: got %0d, expected 1", done_cnt);
      end
      sent_q.delete();
      wait_done(600, ok);
      vectors++;
      if (!ok || got4() !== {24'd2, 24'd3, 24'd4, 24'd5}) begin
         miscompares++; $display("FAIL step1_frame2: got %h, expected 000002000003000004000005", got4());
      end
      vectors++;
      if (last_gap !== 200) begin
         miscompares++; $display("FAIL frame_period: got %0d, expected 200", last_gap);
      end
      vectors++;
      if (done_busy_seen !== 1'b0) begin
         miscompares++; $display("FAIL done_busy_overlap: got %0d, expected 0", done_busy_seen);
      end
   endtask

   task automatic test_step3();
      int n;
      bit ok;
      sif.stepIN = 3'd3;
      restart(n);
      wait_done(600, ok);
      vectors++;
      if (!ok || got4() !== {24'd3, 24'd4, 24'd5, 24'd6}) begin
         miscompares++; $display("FAIL step3_off3: got %h, expected 000003000004000005000006", got4());
      end
      sent_q.delete();
      wait_done(600, ok);
      vectors++;
      if (!ok || got4() !== {24'd6, 24'd7, 24'd0, 24'd1}) begin
         miscompares++; $display("FAIL step3_off6: got %h, expected 000006000007000000000001", got4());
      end
      sent_q.delete();
      wait_done(600, ok);
      vectors++;
      if (!ok || got4() !== {24'd1, 24'd2, 24'd3, 24'd4}) begin
         miscompares++; $display("FAIL step3_off1: got %h, expected 000001000002000003000004", got4());
      end
   endtask

   task automatic test_dir_down();
      int n;
      bit ok;
      sif.stepIN = 3'd1; sif.directionIN = 1'b1;
      restart(n);
      wait_done(600, ok);
      vectors++;
      if (!ok || got4() !== {24'd7, 24'd0, 24'd1, 24'd2}) begin
         miscompares++; $display("FAIL down_off7: got %h, expected 000007000000000001000002", got4());
      end
      sent_q.delete();
      wait_done(600, ok);
      vectors++;
      if (!ok || got4() !== {24'd6, 24'd7, 24'd0, 24'd1}) begin
         miscompares++; $display("FAIL down_off6: got %h, expected 000006000007000000000001", got4());
      end
   endtask

   task automatic test_brightness();
      bit ok;
      sif.directionIN = 1'b0; rom_mode = 1'b1; sif.brightnessIN = 8'd127;
      sent_q.delete();
      wait_start(400, ok);
      sif.brightnessIN = 8'd0;
      wait_done(400, ok);
      vectors++;
      if (!ok || got4() !== {4{24'h646464}}) begin
         miscompares++; $display("FAIL bright127: got %h, expected 4x646464", got4());
      end
      sent_q.delete();
      wait_done(600, ok);
      vectors++;
      if (!ok || got4() !== {4{24'h000000}}) begin
         miscompares++; $display("FAIL bright0: got %h, expected 4x000000", got4());
      end
      rom_mode = 1'b0; sif.brightnessIN = 8'd255;
   endtask

   task automatic test_enable();
      int n, s0;
      bit ok;
      sif.stepIN = 3'd1;
      restart(n);
      sif.enableIN = 1'b0;
      wait_done(400, ok);
      vectors++;
      if (!ok || got4() !== {24'd1, 24'd2, 24'd3, 24'd4}) begin
         miscompares++; $display("FAIL enable_drop_frame: got %h, expected 000001000002000003000004", got4());
      end
      s0 = starts;
      repeat (450) @(posedge clk_in); #1;
      vectors++;
      if (starts !== s0) begin
         miscompares++; $display("FAIL disabled_starts: got %0d, expected %0d", starts, s0);
      end
      sif.enableIN = 1'b1;
      sent_q.delete();
      wait_done(600, ok);
      vectors++;
      if (!ok || got4() !== {24'd2, 24'd3, 24'd4, 24'd5}) begin
         miscompares++; $display("FAIL reenable_frame: got %h, expected 000002000003000004000005", got4());
      end
   endtask

   task automatic test_overrun();
      int n;
      bit ok;
      busy_len = 300;
      restart(n);
      wait_done(2000, ok);
      vectors++;
      if (!ok || got4() !== {24'd1, 24'd2, 24'd3, 24'd4}) begin
         miscompares++; $display("FAIL slow_frame1: got %h, expected 000001000002000003000004", got4());
      end
      vectors++;
      if (ovr_cnt !== 6) begin
         miscompares++; $display("FAIL overrun_count: got %0d, expected 6", ovr_cnt);
      end
      sent_q.delete();
      wait_start(600, ok);
      vectors++;
      if (!ok || last_gap !== 1400) begin
         miscompares++; $display("FAIL slow_start_gap: got %0d, expected 1400", last_gap);
      end
      wait_done(2000, ok);
      vectors++;
      if (!ok || got4() !== {24'd2, 24'd3, 24'd4, 24'd5}) begin
         miscompares++; $display("FAIL slow_frame2: got %h, expected 000002000003000004000005", got4());
      end
      busy_len = 10;
   endtask

   task automatic test_reset_mid_frame();
      int n;
      bit ok;
      wait_start(400, ok);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk_in); #1;
         if (sif.txStartOUT) break;
      end
      repeat (4) @(posedge clk_in);
      @(negedge clk_in); #2;
      n_reset = 1'b0;
      #1;
      vectors++;
      if (!ok || {sif.busyOUT, sif.txStartOUT, sif.frameDoneOUT, sif.overrunOUT,
                  sif.romAddressOUT, sif.txDataOUT} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: got busy=%b addr=%0d data=%h, expected all 0",
                  sif.busyOUT, sif.romAddressOUT, sif.txDataOUT);
      end
      sif.stepIN = 3'd2;
      repeat (2) @(posedge clk_in);
      release_and_wait(n);
      vectors++;
      if (n !== 200) begin
         miscompares++; $display("FAIL post_reset_start: got %0d, expected 200", n);
      end
      wait_done(600, ok);
      vectors++;
      if (!ok || got4() !== {24'd2, 24'd3, 24'd4, 24'd5}) begin
         miscompares++; $display("FAIL post_reset_frame: got %h, expected 000002000003000004000005", got4());
      end
   endtask

   initial begin
      sif.enableIN     = 1'b0;
      sif.directionIN  = 1'b0;
      sif.stepIN       = 3'd1;
      sif.brightnessIN = 8'd255;
      test_reset();
      test_scroll_step1();
      test_step3();
      test_dir_down();
      test_brightness();
      test_enable();
      test_overrun();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ws2811_frame_sequencer.md
# ws2811_frame_sequencer

Parametrised frame sequencer that streams one pattern frame per update period from a pattern ROM to a WS2811 transmitter. Generalises the fixed top-level sequencing loop: configurable unit count, pattern depth, ROM latency and colour width, plus run-time scroll direction, step size, brightness scaling and overrun detection. It sits between the pattern ROM and the WS2811 transmitter, which stays a separate instance. It replaces the race-prone start/busy coupling with an explicit start/busy handshake.

## Interface
- UNITS_NUMBER, 100: pixels per frame, ≥1
- PATTERN_PIXELS_NUMBER, 128: ROM depth; any value ≥2 allowed, need not be a power of two
- CLOCK_SPEED, 50_000_000: clkIN frequency in Hz
- UPDATES_PER_SECOND, 20: frame rate; period P = CLOCK_SPEED/UPDATES_PER_SECOND cycles
- ROM_LATENCY, 1: cycles from romAddressOUT to valid romDataIN, ≥1
- COLOR_WIDTH, 8: bits per colour; pixel word D = 3*COLOR_WIDTH
- Derived: AW = $clog2(PATTERN_PIXELS_NUMBER); UW = $clog2(UNITS_NUMBER+1)

Ports:
- clkIN  in  1  single clock
- nResetIN  in  1  reset, asynchronous, active-low
- enableIN  in  1  frames start only while 1
- directionIN  in  1  0: offset += step; 1: offset -= step, per frame
- stepIN  in  AW  scroll step per frame, sampled at frame start
- brightnessIN  in  8  global scale, sampled at frame start
- romAddressOUT  out  AW  ROM address, registered
- romDataIN  in  D  ROM word
- txStartOUT  out  1  one-cycle start pulse to transmitter
- txDataOUT  out  D  scaled pixel, stable from txStartOUT until the next fetch
- txBusyIN  in  1  transmitter busy
- busyOUT  out  1  high whenever state ≠ IDLE
- frameDoneOUT  out  1  one-cycle pulse after the last unit completes
- overrunOUT  out  1  one-cycle pulse when a tick arrives while not IDLE

## Operation
- Tick counter counts 0..P-1 continuously, independent of state. Tick pulse is issued at P-1. The counter is not gated by enableIN.
- States: IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE + tick + enableIN:
  - offset ← (offset ± stepIN) mod PATTERN_PIXELS_NUMBER.
  - romAddressOUT ← the new offset, unit ← 0.
  - Latch brightness.
  - Go to FETCH.
- IDLE + tick + !enableIN: tick is ignored; offset is unchanged.
- FETCH: wait ROM_LATENCY cycles, capture the scaled romDataIN into txDataOUT, go to ISSUE.
- ISSUE:
  - If txBusyIN=0: txStartOUT=1 for this cycle, go to WAIT_ACK.
  - Otherwise stay in ISSUE.
- WAIT_ACK: wait for txBusyIN=1, then go to WAIT_DONE.
- WAIT_DONE: wait for txBusyIN=0, then unit ← unit+1.
  - If unit+1 = UNITS_NUMBER: pulse frameDoneOUT, go to IDLE.
  - Otherwise romAddressOUT ← (addr+1) mod PATTERN_PIXELS_NUMBER (wrap to 0 past the last entry), go to FETCH.
- Modular arithmetic: compute in AW+1 bits, subtract PATTERN_PIXELS_NUMBER if ≥ it, add it if negative. No reliance on natural wrap.
- Scaling: per colour c, out = (c * (brightness+1)) >> 8, in COLOR_WIDTH+9 bit intermediate. brightness=255 passes c unchanged; brightness=0 gives c>>8 (0 for COLOR_WIDTH=8).
- Tick while not IDLE: pulse overrunOUT, frame in progress continues, tick is dropped. No queued start.
- enableIN falling mid-frame: current frame completes; no new frame starts.
- stepIN/directionIN/brightnessIN changes mid-frame: no effect until the next frame start.

## Timing
- Reset (async assert, sync release): state IDLE, tick counter 0, offset 0, unit 0. All outputs 0.
- First possible frame start is at cycle P-1 after reset release.
- ROM address is driven the cycle the state enters FETCH. Data is captured after exactly ROM_LATENCY cycles.
- Tick in IDLE to first txStartOUT: ROM_LATENCY+2 cycles, provided txBusyIN=0.
- Per-unit overhead beyond transmitter busy time: ROM_LATENCY+3 cycles.
- frameDoneOUT is asserted the cycle after txBusyIN falls for the last unit. busyOUT falls in the same cycle.
- Reset asserted mid-frame: immediate return to IDLE. txStartOUT drops at once. Any transmitter activity is not tracked.

## Structure
- Package ws2811_pkg holds:
  - the state enum type;
  - a shared pixel width function;
  - a scaling function reused by other colour blocks.
- Sub-module ws2811_frame_ticker: the parametrised tick counter (P-cycle period, async reset). It is reused by future blocks.
- ROM and WS2811 transmitter are instantiated beside this block, not inside it.

## Test plan
Bench parameters: UNITS_NUMBER=4, PATTERN=8, P=200, ROM_LATENCY=1. ROM word = address; transmitter model busy 10 cycles.
- Enable, step=1, dir=0, brightness=255 → frame 1 sends 1,2,3,4; frame 2 sends 2,3,4,5; one frameDoneOUT per frame.
- step=3 across frames → offset wraps 0→3→6→1; a frame starting at offset 6 sends 6,7,0,1.
- dir=1, step=1 from offset 0 → offset 7; a frame sends 7,0,1,2.
- Transmitter busy 300 cycles per unit → overrunOUT pulses at each tick during the frame; frames never overlap; offsets advance only at accepted starts.
- brightness=127, word 0xC8 per colour → each colour sent as 0x64; brightness=0 → 0x00.
- Reset asserted during WAIT_DONE → all outputs 0 at once; after release, the first frame starts at P-1 from offset step.
